// File: rtl/mux_x4_pkg.sv
// Shared select codes, reset pointer and round-robin pick function for the 4:1 stream merger.
package mux_x4_pkg;

  localparam logic [1:0] SEL_A        = 2'd0;
  localparam logic [1:0] SEL_B        = 2'd1;
  localparam logic [1:0] SEL_C        = 2'd2;
  localparam logic [1:0] SEL_D        = 2'd3;
  localparam logic [1:0] RR_RESET_PTR = 2'd3;

  // Returns {found, idx}: first valid channel searching ptr+1, ptr+2, ptr+3, ptr+4 (mod 4).
  // Scanning from the farthest candidate lets the nearest one overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (valid[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_x4.sv
// Combinational 4-way grant from valid[3:0] and the last-granted pointer.
// RR_MUX_FIXED_PRIO_EN selects fixed priority a > b > c > d instead of round-robin.
module rr_arbiter_x4
  import mux_x4_pkg::*;
(
  input  logic [3:0] i_valid,
  input  logic [1:0] i_ptr,
  output logic       o_found,
  output logic [1:0] o_grant
);

  logic [2:0] w_pick;

`ifdef RR_MUX_FIXED_PRIO_EN
  // Searching from just after d always visits a, b, c, d in that order.
  assign w_pick = rr_pick(i_valid, SEL_D);
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
`else
  assign w_pick = rr_pick(i_valid, i_ptr);
`endif

  assign o_found = w_pick[2];
  assign o_grant = w_pick[1:0];

endmodule

// File: rtl/rr_mux_nbit_x4.sv
// Round-robin 4:1 N-bit stream merger with registered output y and source tag y_sel.
// Build option: RR_MUX_FIXED_PRIO_EN switches arbitration to fixed priority a > b > c > d.
module rr_mux_nbit_x4
  import mux_x4_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [1:0]           y_sel,
  output logic                 y_valid,
  input  logic                 y_ready
);

  logic [BUS_WIDTH-1:0] r_y;
  logic [1:0]           r_y_sel;
  logic                 r_y_valid;
  logic [1:0]           w_ptr;
  logic                 w_found;
  logic [1:0]           w_grant;
  logic                 w_load_en;
  logic                 w_xfer;
  logic [BUS_WIDTH-1:0] w_data;

  assign w_load_en = !r_y_valid || y_ready;
  assign w_xfer    = w_load_en && w_found;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign w_ptr = RR_RESET_PTR;
`else
  logic [1:0] r_last_grant;

  // Remember the most recent winner so the next search starts just after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= RR_RESET_PTR;
    end else if (w_xfer) begin
      r_last_grant <= w_grant;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  assign w_ptr = r_last_grant;
`endif

  rr_arbiter_x4 u_arb (
    .i_valid ({d_valid, c_valid, b_valid, a_valid}),
    .i_ptr   (w_ptr),
    .o_found (w_found),
    .o_grant (w_grant)
  );

  // Steer the granted channel's data toward the output register.
  always_comb begin
    w_data = '0;
    case (w_grant)
      SEL_A:   w_data = a;
      SEL_B:   w_data = b;
      SEL_C:   w_data = c;
      SEL_D:   w_data = d;
      default: w_data = '0;
    endcase
  end

  // Readies stay low throughout reset regardless of the arbiter.
  assign a_ready = reset_n && w_xfer && (w_grant == SEL_A);
  assign b_ready = reset_n && w_xfer && (w_grant == SEL_B);
  assign c_ready = reset_n && w_xfer && (w_grant == SEL_C);
  assign d_ready = reset_n && w_xfer && (w_grant == SEL_D);

  // Output slot: load on a grant, empty on an idle drain, hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y       <= '0;
      r_y_sel   <= SEL_A;
      r_y_valid <= 1'b0;
    end else if (w_xfer) begin
      r_y       <= w_data;
      r_y_sel   <= w_grant;
      r_y_valid <= 1'b1;
    end else if (w_load_en) begin
      r_y       <= r_y;
      r_y_sel   <= r_y_sel;
      r_y_valid <= 1'b0;
    end else begin
      r_y       <= r_y;
      r_y_sel   <= r_y_sel;
      r_y_valid <= r_y_valid;
    end
  end

  assign y       = r_y;
  assign y_sel   = r_y_sel;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_rr_mux_nbit_x4.sv
// Directed self-checking bench for rr_mux_nbit_x4 (default round-robin build).
module tb_rr_mux_nbit_x4;

  logic       clk;
  logic       reset_n;
  logic [7:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [7:0] y;
  logic [1:0] y_sel;
  logic       y_valid;
  logic       y_ready;
  logic [3:0] rdy;

  int checks   = 0;
  int failures = 0;

  assign rdy = {d_ready, c_ready, b_ready, a_ready};

  rr_mux_nbit_x4 #(.BUS_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .c       (c),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y       (y),
    .y_sel   (y_sel),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valids(input logic [3:0] v);
    {d_valid, c_valid, b_valid, a_valid} = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    y_ready = 1'b1;
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    set_valids(4'b1111);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (y !== 8'h00 || y_sel !== 2'd0 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: y=%h sel=%0d valid=%b, need y=00 sel=0 valid=0", y, y_sel, y_valid);
    end
    checks++;
    if (rdy !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready: ready=%b, need 0000", rdy);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: ready=%b, need 0001", rdy);
    end
    step();
    checks++;
    if (y !== 8'h11 || y_sel !== 2'd0 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_word: y=%h sel=%0d valid=%b, need y=11 sel=0 valid=1", y, y_sel, y_valid);
    end
    set_valids(4'b0000);
    step();
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain: valid=%b, need 0", y_valid);
    end
  endtask

  task automatic test_single();
    c = 8'h5A;
    set_valids(4'b0100);
    #1;
    checks++;
    if (rdy !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: ready=%b, need 0100", rdy);
    end
    step();
    checks++;
    if (y !== 8'h5A || y_sel !== 2'd2 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_word: y=%h sel=%0d valid=%b, need y=5a sel=2 valid=1", y, y_sel, y_valid);
    end
    set_valids(4'b0000);
    step();
    checks++;
    if (y_valid !== 1'b0 || y !== 8'h5A || y_sel !== 2'd2) begin
      failures++;
      $display("FAIL single_drain: y=%h sel=%0d valid=%b, need y=5a sel=2 valid=0", y, y_sel, y_valid);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_y [4];
    exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h33; exp_y[3] = 8'h44;
    // Park the pointer on d so the rotation begins at a.
    d = 8'h44;
    set_valids(4'b1000);
    step();
    checks++;
    if (y !== 8'h44 || y_sel !== 2'd3 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL fair_park_d: y=%h sel=%0d valid=%b, need y=44 sel=3 valid=1", y, y_sel, y_valid);
    end
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    set_valids(4'b1111);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (y_sel !== 2'(i % 4) || y !== exp_y[i % 4] || y_valid !== 1'b1) begin
        failures++;
        $display("FAIL fair_rotate[%0d]: y=%h sel=%0d valid=%b, need y=%h sel=%0d valid=1",
                 i, y, y_sel, y_valid, exp_y[i % 4], i % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    step();
    step();
    checks++;
    if (y !== 8'h22 || y_sel !== 2'd1 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_setup: y=%h sel=%0d valid=%b, need y=22 sel=1 valid=1", y, y_sel, y_valid);
    end
    y_ready = 1'b0;
    #1;
    checks++;
    if (rdy !== 4'b0000) begin
      failures++;
      $display("FAIL bp_ready_now: ready=%b, need 0000", rdy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (y !== 8'h22 || y_sel !== 2'd1 || y_valid !== 1'b1 || rdy !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold[%0d]: y=%h sel=%0d valid=%b ready=%b, need y=22 sel=1 valid=1 ready=0000",
                 i, y, y_sel, y_valid, rdy);
      end
    end
    y_ready = 1'b1;
    #1;
    checks++;
    if (rdy !== 4'b0100) begin
      failures++;
      $display("FAIL bp_release_ready: ready=%b, need 0100", rdy);
    end
    step();
    checks++;
    if (y !== 8'h33 || y_sel !== 2'd2 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume: y=%h sel=%0d valid=%b, need y=33 sel=2 valid=1", y, y_sel, y_valid);
    end
    set_valids(4'b0000);
    step();
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: valid=%b, need 0", y_valid);
    end
  endtask

  task automatic test_skip_wrap();
    // Pointer now sits on c; only a and b compete.
    a = 8'hA1; b = 8'hB2;
    set_valids(4'b0011);
    #1;
    checks++;
    if (rdy !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_ready_a: ready=%b, need 0001", rdy);
    end
    step();
    checks++;
    if (y !== 8'hA1 || y_sel !== 2'd0 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_word_a: y=%h sel=%0d valid=%b, need y=a1 sel=0 valid=1", y, y_sel, y_valid);
    end
    checks++;
    if (rdy !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_ready_b: ready=%b, need 0010", rdy);
    end
    step();
    checks++;
    if (y !== 8'hB2 || y_sel !== 2'd1 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_word_b: y=%h sel=%0d valid=%b, need y=b2 sel=1 valid=1", y, y_sel, y_valid);
    end
    set_valids(4'b0000);
    step();
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_drain: valid=%b, need 0", y_valid);
    end
  endtask

  task automatic test_midop_reset();
    c = 8'hC3;
    set_valids(4'b0100);
    step();
    checks++;
    if (y !== 8'hC3 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_load: y=%h valid=%b, need y=c3 valid=1", y, y_valid);
    end
    set_valids(4'b0000);
    #2;
    reset_n = 1'b0;
    set_valids(4'b1111);
    #1;
    checks++;
    if (y_valid !== 1'b0 || y !== 8'h00 || y_sel !== 2'd0 || rdy !== 4'b0000) begin
      failures++;
      $display("FAIL mid_async_clear: y=%h sel=%0d valid=%b ready=%b, need y=00 sel=0 valid=0 ready=0000",
               y, y_sel, y_valid, rdy);
    end
    @(posedge clk);
    #1;
    set_valids(4'b0000);
    reset_n = 1'b1;
    step();
    checks++;
    if (y_valid !== 1'b0 || y !== 8'h00) begin
      failures++;
      $display("FAIL mid_no_replay: y=%h valid=%b, need y=00 valid=0", y, y_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_skip_wrap();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
